// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction prefetch queue between the InstROM port and the fetch/decode
//   buffer. It issues sequential fetch addresses ahead of decode to a
//   pipelined, in-order ROM. Returned {pc, instr} pairs are buffered in a
//   small FIFO and presented downstream with a valid/ready handshake. A
//   branch/jump redirect flushes the queue and restarts fetch at the target.
//   Responses that were already in flight when the redirect happened are
//   discarded while the queue is in DRAIN.
//
// Parameters
//   PC_W      program counter width (word address, +1 per instruction)
//   INSTR_W   instruction width
//   DEPTH     FIFO entries (power of 2, >= 2); also caps outstanding requests
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-low
//   redirect_valid in   branch taken / jump resolved this cycle
//   redirect_pc    in   restart address
//   rom_req_valid  out  fetch request to ROM
//   rom_req_addr   out  fetch address
//   rom_rsp_valid  in   ROM response (in order, latency >= 1, never stalls)
//   rom_rsp_instr  in   returned instruction
//   out_valid      out  queue head valid
//   out_ready      in   downstream accepts (low = FD stall)
//   out_pc         out  pc of head instruction (0 when not valid)
//   out_instr      out  head instruction (0 when not valid)
//   count          out  occupied FIFO entries
//
// Build option
//   IF_PREFETCH_BYPASS_EN : when the FIFO is empty in RUN with no redirect, an
//   arriving response is shown on the outputs in the same cycle and skips the
//   FIFO if it is accepted at once. Undefined: every response goes through
//   the FIFO (one cycle of latency).
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     rom_req_valid,
  output logic [PC_W-1:0]          rom_req_addr,
  input  logic                     rom_rsp_valid,
  input  logic [INSTR_W-1:0]       rom_rsp_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]      head_ptr, tail_ptr;
  logic [CW-1:0]      count_q, count_next;
  logic [CW-1:0]      inflight, inflight_next;
  logic [PC_W-1:0]    fetch_pc, rsp_pc;
  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];

  logic fifo_empty;
  logic has_room;
  logic rsp_accept;
  logic bypass_hit;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign count      = count_q;

  // Entries already buffered plus requests still in the ROM pipeline never
  // exceed DEPTH, so every accepted response is guaranteed a free slot.
  assign has_room = ({1'b0, count_q} + {1'b0, inflight}) < DEPTH_OCC;

  // A response is kept only in RUN and only when no redirect is flushing the
  // queue this cycle; rst gating keeps outputs quiet while reset is held.
  assign rsp_accept = rst && (state == ST_RUN) && !redirect_valid && rom_rsp_valid;

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass_hit = rsp_accept && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed response that is taken immediately never occupies a slot.
  assign push = rsp_accept && !(bypass_hit && out_ready);
  assign pop  = !fifo_empty && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a redirect or an ongoing drain lands in DRAIN while stale
  // responses remain outstanding after this cycle, otherwise in RUN.
  always_comb begin
    state_next = state;
    if (redirect_valid || (state == ST_DRAIN)) begin
      state_next = (inflight_next != '0) ? ST_DRAIN : ST_RUN;
    end
  end

  // Outputs: fetch issue and the queue head (or the bypassed response).
  always_comb begin
    rom_req_valid = rst && (state == ST_RUN) && !redirect_valid && has_room;
    rom_req_addr  = fetch_pc;
    out_valid     = !fifo_empty;
    out_pc        = '0;
    out_instr     = '0;
    if (!fifo_empty) begin
      out_pc    = mem_pc[head_ptr];
      out_instr = mem_instr[head_ptr];
    end
    if (bypass_hit) begin
      out_valid = 1'b1;
      out_pc    = rsp_pc;
      out_instr = rom_rsp_instr;
    end
  end

  // Outstanding request tracking; issue and response together cancel out.
  always_comb begin
    inflight_next = inflight;
    if (rom_req_valid && !rom_rsp_valid) begin
      inflight_next = inflight + CW'(1);
    end else if (!rom_req_valid && rom_rsp_valid) begin
      inflight_next = inflight - CW'(1);
    end
  end

  // Occupancy: a redirect empties the queue regardless of push/pop.
  always_comb begin
    count_next = count_q;
    if (redirect_valid) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (!push && pop) begin
      count_next = count_q - CW'(1);
    end
  end

  // Pointers, counters and fetch/response pc tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      inflight <= '0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else begin
      inflight <= inflight_next;
      count_q  <= count_next;
      if (redirect_valid) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
      end else begin
        if (rom_req_valid) begin
          fetch_pc <= fetch_pc + PC_W'(1);
        end
        if (rsp_accept) begin
          rsp_pc <= rsp_pc + PC_W'(1);
        end
        if (push) begin
          tail_ptr <= tail_ptr + AW'(1);
        end
        if (pop) begin
          head_ptr <= head_ptr + AW'(1);
        end
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail_ptr]    <= rsp_pc;
      mem_instr[tail_ptr] <= rom_rsp_instr;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_queue
//   Self-checking bench for if_prefetch_queue (DEPTH 4, PC_W 8, INSTR_W 32).
//   A cycle table drives the ROM response by hand for the fill/stall/redirect
//   path; hand-written sequences use a small pipelined ROM model with
//   selectable latency for streaming, reset, drain, wrap and bypass corners.
//   Instruction contents are a fixed function of the address so every
//   returned pc/instr pair can be predicted.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        rom_req_valid;
  logic [7:0]  rom_req_addr;
  logic        rom_rsp_valid;
  logic [31:0] rom_rsp_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  logic        model_en;
  int          lat;
  logic        man_v;
  logic [31:0] man_instr;
  logic [4:1]  pipe_v;
  logic [7:0]  pipe_a [1:4];

  int n_cmp;
  int n_fail;

  typedef struct {
    logic       rdv;
    logic [7:0] rdpc;
    logic       rsv;
    logic [7:0] rsp_addr;
    logic       rdy;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_ov;
    logic [7:0] e_pc;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl [15];

  if_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_req_valid  (rom_req_valid),
    .rom_req_addr   (rom_req_addr),
    .rom_rsp_valid  (rom_rsp_valid),
    .rom_rsp_instr  (rom_rsp_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [7:0] a);
    return {a ^ 8'h5A, 8'hC3, ~a, a};
  endfunction

  function automatic vec_t mk(input logic rdv, input logic [7:0] rdpc,
                              input logic rsv, input logic [7:0] rsp_addr,
                              input logic rdy, input logic e_req,
                              input logic [7:0] e_addr, input logic e_ov,
                              input logic [7:0] e_pc, input logic [2:0] e_cnt);
    vec_t v;
    v.rdv = rdv; v.rdpc = rdpc; v.rsv = rsv; v.rsp_addr = rsp_addr;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov;
    v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Pipelined in-order ROM model: a request shows up as a response lat cycles later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[3:1], rom_req_valid};
      pipe_a[4] <= pipe_a[3];
      pipe_a[3] <= pipe_a[2];
      pipe_a[2] <= pipe_a[1];
      pipe_a[1] <= rom_req_addr;
    end
  end

  // Response source: ROM model or direct drive from the cycle table.
  always_comb begin
    if (model_en) begin
      rom_rsp_valid = pipe_v[lat];
      rom_rsp_instr = instr_of(pipe_a[lat]);
    end else begin
      rom_rsp_valid = man_v;
      rom_rsp_instr = man_instr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic set_in(input logic rdy, input logic rdv, input logic [7:0] rdpc,
                        input logic mv, input logic [7:0] maddr);
    out_ready      = rdy;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    man_v          = mv;
    man_instr      = instr_of(maddr);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    set_in(v.rdy, v.rdv, v.rdpc, v.rsv, v.rsp_addr);
  endtask

  // Ends on the negedge at which reset is released (cycle 0 of the new run).
  task automatic do_reset(input logic model, input int latency, input logic rdy);
    rst            = 1'b0;
    model_en       = model;
    lat            = latency;
    out_ready      = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    man_v          = 1'b0;
    man_instr      = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int n = 0; n < budget && !out_valid; n++) begin
      adv();
      #1;
    end
    checkOutput(name, 32'(out_valid), 32'd1);
  endtask

  task automatic check_head(input string name, input logic [7:0] pc);
    checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, " pc"}, 32'(out_pc), 32'(pc));
    checkOutput({name, " instr"}, out_instr, instr_of(pc));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int exp_pc;
    int bub;
    logic [7:0] ep;

    n_cmp  = 0;
    n_fail = 0;

    // Fill to full under stall, drain with pops, redirect with one stale response.
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0,  1, 8'h00, 0, 8'h00, 3'd0);
    tbl[1]  = mk(0, 8'h00, 1, 8'h00, 0,  1, 8'h01, 0, 8'h00, 3'd0);
    tbl[2]  = mk(0, 8'h00, 1, 8'h01, 0,  1, 8'h02, 1, 8'h00, 3'd1);
    tbl[3]  = mk(0, 8'h00, 1, 8'h02, 0,  1, 8'h03, 1, 8'h00, 3'd2);
    tbl[4]  = mk(0, 8'h00, 1, 8'h03, 0,  0, 8'h04, 1, 8'h00, 3'd3);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 8'h04, 1, 8'h00, 3'd4);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h04, 1, 8'h00, 3'd4);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 1,  1, 8'h04, 1, 8'h01, 3'd3);
    tbl[8]  = mk(0, 8'h00, 1, 8'h04, 1,  1, 8'h05, 1, 8'h02, 3'd2);
    tbl[9]  = mk(0, 8'h00, 1, 8'h05, 1,  1, 8'h06, 1, 8'h03, 3'd2);
    tbl[10] = mk(1, 8'h40, 0, 8'h00, 1,  0, 8'h07, 1, 8'h04, 3'd2);
    tbl[11] = mk(0, 8'h00, 1, 8'h06, 1,  0, 8'h40, 0, 8'h00, 3'd0);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 1,  1, 8'h40, 0, 8'h00, 3'd0);
    tbl[13] = mk(0, 8'h00, 1, 8'h40, 0,  1, 8'h41, 0, 8'h00, 3'd0);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 0,  1, 8'h42, 1, 8'h40, 3'd1);

`ifndef IF_PREFETCH_BYPASS_EN
    do_reset(1'b0, 1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("row%0d req_valid", i), 32'(rom_req_valid), 32'(tbl[i].e_req));
      checkOutput($sformatf("row%0d req_addr", i), 32'(rom_req_addr), 32'(tbl[i].e_addr));
      checkOutput($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      checkOutput($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_ov) begin
        checkOutput($sformatf("row%0d out_pc", i), 32'(out_pc), 32'(tbl[i].e_pc));
        checkOutput($sformatf("row%0d out_instr", i), out_instr, instr_of(tbl[i].e_pc));
      end
      adv();
    end
`endif

    // Streaming at ROM latency 1 with downstream always ready.
    do_reset(1'b1, 1, 1'b1);
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("stream first req_valid", 32'(rom_req_valid), 32'd1);
    checkOutput("stream first req_addr", 32'(rom_req_addr), 32'h00);
    checkOutput("stream c0 out_valid", 32'(out_valid), 32'd0);
    adv();
    #1;
`ifdef IF_PREFETCH_BYPASS_EN
    checkOutput("stream c1 out_valid", 32'(out_valid), 32'd1);
`else
    checkOutput("stream c1 out_valid", 32'(out_valid), 32'd0);
    adv();
    #1;
`endif
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("stream pc%0d", i), 8'(i));
      adv();
      #1;
    end

    // Asynchronous reset in the middle of the stream, away from a clock edge.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset req_valid", 32'(rom_req_valid), 32'd0);
    checkOutput("async reset count", 32'(count), 32'd0);
    checkOutput("async reset out_pc", 32'(out_pc), 32'd0);
    checkOutput("async reset out_instr", out_instr, 32'd0);
    adv();
    do_reset(1'b1, 1, 1'b1);
    #1;
    checkOutput("post reset req_valid", 32'(rom_req_valid), 32'd1);
    checkOutput("post reset req_addr", 32'(rom_req_addr), 32'h00);
    adv();

    // Stall until full, then release and expect in-order drain and refill.
    do_reset(1'b1, 1, 1'b0);
    #1;
    repeat (8) begin
      adv();
      #1;
    end
    checkOutput("stall count full", 32'(count), 32'd4);
    checkOutput("stall req_valid", 32'(rom_req_valid), 32'd0);
    check_head("stall head", 8'h00);
    adv();
    #1;
    checkOutput("stall count held", 32'(count), 32'd4);
    checkOutput("stall req held", 32'(rom_req_valid), 32'd0);
    checkOutput("stall pc held", 32'(out_pc), 32'h00);
    out_ready = 1'b1;
    #1;
    exp_pc = 0;
    bub    = 0;
    for (int n = 0; n < 10 && exp_pc < 6; n++) begin
      if (out_valid) begin
        checkOutput($sformatf("release pc%0d", exp_pc), 32'(out_pc), 32'(exp_pc));
        checkOutput($sformatf("release instr%0d", exp_pc), out_instr, instr_of(8'(exp_pc)));
        exp_pc++;
      end else if (exp_pc > 0) begin
        bub++;
      end
      adv();
      #1;
    end
    checkOutput("release drained", 32'(exp_pc), 32'd6);
    checkOutput("release bubbles ok", 32'(bub <= 1), 32'd1);

    // Redirect to 0x40 with two requests in flight at ROM latency 3.
    do_reset(1'b1, 3, 1'b1);
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("drain c0 req_addr", 32'(rom_req_addr), 32'h00);
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("drain c1 req_valid", 32'(rom_req_valid), 32'd1);
    checkOutput("drain c1 req_addr", 32'(rom_req_addr), 32'h01);
    adv();
    set_in(1, 1, 8'h40, 0, 8'h00);
    checkOutput("redirect cycle req_valid", 32'(rom_req_valid), 32'd0);
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("drain c3 req_valid", 32'(rom_req_valid), 32'd0);
    checkOutput("drain c3 out_valid", 32'(out_valid), 32'd0);
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("drain c4 req_valid", 32'(rom_req_valid), 32'd0);
    checkOutput("drain c4 out_valid", 32'(out_valid), 32'd0);
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("drain c5 req_valid", 32'(rom_req_valid), 32'd1);
    checkOutput("drain c5 req_addr", 32'(rom_req_addr), 32'h40);
    wait_valid("drain wait out_valid", 8);
    check_head("drain first head", 8'h40);
    adv();

    // Redirect near the top of the address space: pcs wrap 0xFF -> 0x00.
    do_reset(1'b1, 1, 1'b1);
    set_in(1, 0, 8'h00, 0, 8'h00);
    adv();
    set_in(1, 1, 8'hFE, 0, 8'h00);
    checkOutput("wrap redirect req_valid", 32'(rom_req_valid), 32'd0);
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
    wait_valid("wrap wait out_valid", 8);
    for (int i = 0; i < 4; i++) begin
      ep = 8'hFE + 8'(i);
      check_head($sformatf("wrap pc%0d", i), ep);
      adv();
      #1;
    end

    // Single response into an empty FIFO: bypass timing versus FIFO timing.
    do_reset(1'b0, 1, 1'b1);
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("single req_addr", 32'(rom_req_addr), 32'h00);
    adv();
    set_in(1, 0, 8'h00, 1, 8'h00);
`ifdef IF_PREFETCH_BYPASS_EN
    check_head("single c1 bypass", 8'h00);
    checkOutput("single c1 count", 32'(count), 32'd0);
`else
    checkOutput("single c1 out_valid", 32'(out_valid), 32'd0);
    checkOutput("single c1 count", 32'(count), 32'd0);
`endif
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
`ifdef IF_PREFETCH_BYPASS_EN
    checkOutput("single c2 out_valid", 32'(out_valid), 32'd0);
    checkOutput("single c2 count", 32'(count), 32'd0);
`else
    check_head("single c2 head", 8'h00);
    checkOutput("single c2 count", 32'(count), 32'd1);
`endif
    adv();
    set_in(1, 0, 8'h00, 0, 8'h00);
    checkOutput("single c3 out_valid", 32'(out_valid), 32'd0);
    checkOutput("single c3 count", 32'(count), 32'd0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
